// File: rtl/div32_pkg.sv
// Shared types and constants for the sequential 32-bit divider.
package div32_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;
  localparam logic [XLEN-1:0] ONE       = XLEN'(1);

  // Two's-complement magnitude / negation helper: returns -v when neg is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

endpackage

// File: rtl/div32_step.sv
// One restoring-division step: trial subtract of the divisor magnitude from
// the shifted partial remainder, keeping the difference when it is non-negative.
module div32_step
  import div32_pkg::*;
(
  input  logic [XLEN:0]   rem_shift_i,
  input  logic [XLEN-1:0] dsr_i,
  output logic [XLEN-1:0] rem_next_o,
  output logic            q_bit_o
);

  logic [XLEN:0] dsr_ext;
  logic [XLEN:0] diff;
  logic          keep;

  // 33-bit trial difference formed as a + ~b + 1; its MSB is the sign.
  always_comb begin
    dsr_ext    = {1'b0, dsr_i};
    diff       = rem_shift_i + ~dsr_ext + {{XLEN{1'b0}}, 1'b1};
    keep       = ~diff[XLEN];
    q_bit_o    = keep;
    rem_next_o = keep ? diff[XLEN-1:0] : rem_shift_i[XLEN-1:0];
  end

endmodule

// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU/REM/REMU, RISC-V semantics).
// Optional macro DIV32_SEQ_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip the iteration phase and go straight from IDLE to DONE.
module div32_seq
  import div32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        valid,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   prem_q;      // partial remainder magnitude
  logic [XLEN-1:0]   dvd_q;       // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0]   dsr_q;       // divisor magnitude
  logic [XLEN-1:0]   rs1_q;       // raw dividend, needed for the divide-by-zero remainder
  logic              q_neg_q;
  logic              r_neg_q;
  logic              div0_q;
  logic              ovf_q;
  logic              busy_q;
  logic              valid_q;
  logic [XLEN-1:0]   quot_q;
  logic [XLEN-1:0]   rem_q;

  logic              rs1_neg_d;
  logic              rs2_neg_d;
  logic              div0_d;
  logic              ovf_d;
  logic [XLEN:0]     rem_shift;
  logic [XLEN-1:0]   rem_next;
  logic              q_bit;
  logic [XLEN-1:0]   quot_d;
  logic [XLEN-1:0]   rem_d;

  // Operand decode at request time: signs and the two special cases.
  always_comb begin
    rs1_neg_d = is_signed & rs1[XLEN-1];
    rs2_neg_d = is_signed & rs2[XLEN-1];
    div0_d    = (rs2 == '0);
    ovf_d     = is_signed & (rs1 == INT_MIN) & (rs2 == '1);
  end

  assign rem_shift = {prem_q, dvd_q[XLEN-1]};

  div32_step u_step (
    .rem_shift_i (rem_shift),
    .dsr_i       (dsr_q),
    .rem_next_o  (rem_next),
    .q_bit_o     (q_bit)
  );

  // Final correction: special cases override, otherwise re-apply the signs.
  always_comb begin
    if (div0_q) begin
      quot_d = DIV0_QUOT;
      rem_d  = rs1_q;
    end else if (ovf_q) begin
      quot_d = INT_MIN;
      rem_d  = '0;
    end else begin
      quot_d = cond_neg(dvd_q, q_neg_q);
      rem_d  = cond_neg(prem_q, r_neg_q);
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rs1_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            prem_q  <= '0;
            dvd_q   <= cond_neg(rs1, rs1_neg_d);
            dsr_q   <= cond_neg(rs2, rs2_neg_d);
            rs1_q   <= rs1;
            q_neg_q <= rs1_neg_d ^ rs2_neg_d;
            r_neg_q <= rs1_neg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b1;
`ifdef DIV32_SEQ_EARLY_OUT_EN
            if (div0_d || ovf_d) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q   <= CNT_W'(XLEN);
              state_q <= RUN;
            end
`else
            cnt_q   <= CNT_W'(XLEN);
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          prem_q <= rem_next;
          dvd_q  <= {dvd_q[XLEN-2:0], q_bit};
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b1;
          quot_q  <= quot_d;
          rem_q   <= rem_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign quot  = quot_q;
  assign rem   = rem_q;

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard testbench for div32_seq: driver pushes reference results,
// a negedge monitor pops and compares on every valid pulse.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        valid;
  logic [31:0] quot;
  logic [31:0] rem;

  div32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy      (busy),
    .valid     (valid),
    .quot      (quot),
    .rem       (rem)
  );

  always #5 clk = ~clk;

`ifdef DIV32_SEQ_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int unsigned n;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain RISC-V division rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb_;
      r = sa % sb_;
    end
  endfunction

  // Edges from the sampling edge to the edge after which valid is visible.
  function automatic int unsigned exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    bit special;
    special = (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (EARLY && special) ? 1 : 33;
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the sampling edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    check("busy_before_start", {31'd0, busy}, 32'd0);
    rs1 = a;
    rs2 = b;
    is_signed = s;
    start = 1'b1;
    ref_div(a, b, s, e.q, e.r);
    e.n   = cyc + 1;
    e.lat = exp_lat(a, b, s);
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for valid, counting busy cycles on the way.
  task automatic finish_op(input int unsigned lat, input int unsigned consumed);
    int unsigned bcnt = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (valid) seen = 1'b1;
      else begin
        if (busy) bcnt++;
        @(posedge clk);
        #1;
      end
    end
    check("valid_seen", {31'd0, seen}, 32'd1);
    check("busy_cycles", bcnt, lat - consumed);
    check("busy_in_valid_cycle", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: compare each valid pulse against the scoreboard, then the hold cycle.
  bit          hold_pending = 1'b0;
  logic [31:0] hold_q;
  logic [31:0] hold_r;
  always @(negedge clk) begin
    exp_t e;
    if (hold_pending) begin
      check("valid_one_cycle", {31'd0, valid}, 32'd0);
      check("quot_hold", quot, hold_q);
      check("rem_hold", rem, hold_r);
      hold_pending = 1'b0;
    end
    if (valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got valid=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("quot", quot, e.q);
        check("rem", rem, e.r);
        check("latency", cyc - e.n, e.lat);
        hold_q = e.q;
        hold_r = e.r;
        hold_pending = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] da [9] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5,
                          32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
  logic [31:0] db [9] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1};
  logic        ds [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int unsigned sel;

    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    rs1 = '0;
    rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_quot", quot, 32'd0);
    check("reset_rem", rem, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed operands, including zero divisor and signed overflow.
    for (int i = 0; i < 9; i++) begin
      issue(da[i], db[i], ds[i]);
      finish_op(exp_lat(da[i], db[i], ds[i]), 0);
    end

    // A start ten cycles into RUN must be ignored.
    issue(32'd1000, 32'd7, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rs1 = 32'd1; rs2 = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_op(33, 10);
    repeat (40) begin @(posedge clk); #1; end

    // Start in the DONE cycle is ignored; start in the next cycle is taken.
    issue(32'd123456, 32'd789, 1'b0);
    repeat (32) begin @(posedge clk); #1; end
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("no_valid_in_done", {31'd0, valid}, 32'd0);
    rs1 = 32'd42; rs2 = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("valid_after_done", {31'd0, valid}, 32'd1);
    issue(32'd77, 32'd8, 1'b0);
    finish_op(33, 0);

    // Reset in the middle of RUN aborts; a start right after reset is accepted.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_quot", quot, 32'd0);
    check("abort_rem", rem, 32'd0);
    void'(sb.pop_back());
    issue(32'd9, 32'd3, 1'b0);
    finish_op(33, 0);

    // Randomized operands with a bias toward corner divisors.
    for (int i = 0; i < 60; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 7);
      s   = 1'($urandom_range(0, 1));
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: b = a;
        4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        5: b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      issue(a, b, s);
      finish_op(exp_lat(a, b, s), 0);
    end

    repeat (5) begin @(posedge clk); #1; end
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 SHALL have ports, one clock, reset synchronous active-high:
  clk        input   1   rising-edge clock, sole clock
  rst        input   1   synchronous reset, active-high
  start      input   1   request; sampled only when busy=0
  is_signed  input   1   1 = DIV/REM two's-complement, 0 = DIVU/REMU
  rs1        input   32  dividend, sampled with start
  rs2        input   32  divisor, sampled with start
  busy       output  1   operation in progress
  valid      output  1   one-cycle pulse, quot/rem valid
  quot       output  32  quotient
  rem        output  32  remainder

Function
REQ-002 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-003 IDLE with start=1 SHALL latch rs1, rs2 and is_signed, load the iteration counter with 32, and enter RUN.
REQ-004 RUN SHALL perform one restoring step per cycle:
  - shift {partial remainder, dividend} left by 1
  - trial-subtract the magnitude of the divisor (33-bit result)
  - if non-negative, keep the difference and set the quotient LSB to 1
  - otherwise restore and set the quotient LSB to 0
  - decrement the counter; enter DONE when the counter reaches 0
REQ-005 Signed mode SHALL divide magnitudes, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend (RISC-V semantics).
REQ-006 DONE SHALL assert valid for exactly one cycle, drive the final quot/rem, and return to IDLE.
REQ-007 Latency SHALL be 34 cycles: start sampled at edge N, valid high in the cycle after edge N+33.
REQ-008 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-009 start while busy=1 SHALL be ignored, with no queuing.
REQ-010 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-011 quot/rem SHALL hold the last result until the next valid pulse.
REQ-012 Divide by zero SHALL give quot=32'hFFFF_FFFF and rem=rs1, in both modes.
REQ-013 Signed overflow (rs1=32'h8000_0000, rs2=32'hFFFF_FFFF) SHALL give quot=32'h8000_0000 and rem=0.
REQ-014 All arithmetic SHALL be modulo 2^32 except the internal 33-bit trial difference.

Reset
REQ-015 rst=1 at a clock edge SHALL force IDLE, with busy=0, valid=0, quot=0, rem=0 and counter=0.
REQ-016 Reset mid-RUN SHALL abort the operation with no valid pulse; start SHALL be accepted in the first cycle after rst deasserts.
REQ-017 rst SHALL take priority over start in the same cycle.

Configuration
REQ-018 Macro DIV32_SEQ_EARLY_OUT_EN:
  - defined: a divide-by-zero or signed-overflow request SHALL go from IDLE directly to DONE, so valid is high in the cycle after edge N+1 (latency 2).
  - undefined: those cases SHALL run the full 32 iterations with latency 34, and the REQ-012/013 results SHALL be produced by final correction.

Structure
REQ-019 Package div32_pkg SHALL hold:
  - XLEN=32
  - CNT_W=6
  - the state enum typedef {IDLE, RUN, DONE}
  - the constants DIV0_QUOT=32'hFFFF_FFFF and INT_MIN=32'h8000_0000
REQ-020 Sub-module div32_step (combinational) SHALL take the shifted remainder and the divisor magnitude and return the next remainder and the quotient bit.
  - Exactly one instance.
  - Its subtraction SHALL be a two's-complement add (a + ~b + 1).

Verification
REQ-021 Unsigned 100/7 -> valid 34 cycles after start; quot=14, rem=2; busy high for 33 cycles.
REQ-022 Signed -7/2 -> quot=32'hFFFF_FFFD (-3), rem=32'hFFFF_FFFF (-1); signed 7/-2 -> quot=-3, rem=1.
REQ-023 Divide by zero: 5/0 -> quot=32'hFFFF_FFFF, rem=5.
  - with DIV32_SEQ_EARLY_OUT_EN: latency 2
  - without it: latency 34
REQ-024 Signed 32'h8000_0000/32'hFFFF_FFFF -> quot=32'h8000_0000, rem=0; the same operands unsigned -> quot=0, rem=32'h8000_0000.
REQ-025 Second start at cycle 10 of RUN is ignored, and the first result is unchanged.
  - rst at cycle 20 of a new RUN -> busy=0 next cycle, no valid pulse, quot=rem=0.
  - a following start of 9/3 -> quot=3, rem=0.
